// File: rtl/trng_pkg.sv
// Shared types, default parameters and a width helper for the TRNG word collector.
package trng_pkg;

    typedef enum logic {
        PAIR_A = 1'b0,
        PAIR_B = 1'b1
    } pair_state_t;

    localparam int DEFAULT_WIDTH      = 32;
    localparam int DEFAULT_SAMPLE_DIV = 1;
    localparam int DEFAULT_DEBIAS     = 1;
    localparam int DEFAULT_RCT_LIMIT  = 32;

    // Ceiling of log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann corrector: pairs of raw samples, 01 -> 0, 10 -> 1, 00/11 dropped.
module trng_vn_debias
    import trng_pkg::*;
#(
    parameter int DEBIAS = DEFAULT_DEBIAS
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic strobe,
    input  logic sample,
    output logic bit_valid,
    output logic bit_out
);

    pair_state_t state;
    pair_state_t state_next;
    logic        first_bit;

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= PAIR_A;
            first_bit <= 1'b0;
        end else begin
            state <= state_next;
            if (strobe && (state == PAIR_A)) begin
                first_bit <= sample;
            end
        end
    end

    // Dropping enable abandons any half-collected pair.
    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = PAIR_A;
        end else if (strobe) begin
            case (state)
                PAIR_A:  state_next = PAIR_B;
                PAIR_B:  state_next = PAIR_A;
                default: state_next = PAIR_A;
            endcase
        end
    end

    always_comb begin
        bit_valid = 1'b0;
        bit_out   = 1'b0;
        if (DEBIAS == 0) begin
            bit_valid = en && strobe;
            bit_out   = sample;
        end else if (en && strobe && (state == PAIR_B) && (first_bit != sample)) begin
            bit_valid = 1'b1;
            bit_out   = first_bit;
        end
    end

endmodule

// File: rtl/trng_word_collector.sv
// Collects the TRNG serial stream into WIDTH-bit words: synchroniser, sample
// divider, repetition-count health test, packer and double-buffered output.
module trng_word_collector
    import trng_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
    parameter int DEBIAS     = DEFAULT_DEBIAS,
    parameter int RCT_LIMIT  = DEFAULT_RCT_LIMIT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             rand_num,
    output logic [WIDTH-1:0] word_data,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             health_fail,
    output logic             overrun
);

    localparam int FILL_W = clog2(WIDTH + 1);
    localparam int DIV_W  = (clog2(SAMPLE_DIV) > 0) ? clog2(SAMPLE_DIV) : 1;
    localparam int RCT_W  = clog2(RCT_LIMIT + 1);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [RCT_W-1:0]  RCT_MAX   = RCT_W'(RCT_LIMIT);

    logic              sync_1;
    logic              sync_2;
    logic              sample;
    logic [DIV_W-1:0]  div_cnt;
    logic              strobe;
    logic              prev_sample;
    logic [RCT_W-1:0]  rct_cnt;
    logic [RCT_W-1:0]  rct_next;
    logic              bit_valid;
    logic              bit_out;
    logic              accepted;
    logic [WIDTH-1:0]  shift_reg;
    logic [FILL_W-1:0] fill;
    logic              shift_full;
    logic              out_full;
    logic              consume;
    logic              transfer;

    always_ff @(posedge clk) begin
        if (clr) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= rand_num;
            sync_2 <= sync_1;
        end
    end

    assign sample = sync_2;
    assign strobe = en && (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (clr || !en) begin
            div_cnt <= '0;
        end else if (strobe) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // The run counter saturates at the limit so it cannot wrap back below it.
    always_comb begin
        rct_next = rct_cnt;
        if (strobe) begin
            if (sample != prev_sample) begin
                rct_next = RCT_W'(1);
            end else if (rct_cnt != RCT_MAX) begin
                rct_next = rct_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            prev_sample <= 1'b0;
            rct_cnt     <= '0;
            health_fail <= 1'b0;
        end else begin
            if (strobe) begin
                prev_sample <= sample;
            end
            rct_cnt <= rct_next;
            if (rct_next == RCT_MAX) begin
                health_fail <= 1'b1;
            end
        end
    end

    trng_vn_debias #(
        .DEBIAS(DEBIAS)
    ) u_debias (
        .clk       (clk),
        .clr       (clr),
        .en        (en),
        .strobe    (strobe),
        .sample    (sample),
        .bit_valid (bit_valid),
        .bit_out   (bit_out)
    );

    assign accepted   = bit_valid && !health_fail;
    assign word_valid = out_full && !health_fail;
    assign consume    = word_valid && word_ready;
    assign shift_full = (fill == FILL_FULL);
    assign transfer   = shift_full && (!out_full || consume);

    // A bit arriving on a transfer edge starts the next word instead of being lost.
    always_ff @(posedge clk) begin
        if (clr) begin
            word_data <= '0;
            out_full  <= 1'b0;
            shift_reg <= '0;
            fill      <= '0;
            overrun   <= 1'b0;
        end else begin
            if (transfer) begin
                word_data <= shift_reg;
                out_full  <= 1'b1;
            end else if (consume) begin
                out_full <= 1'b0;
            end

            if (transfer) begin
                if (accepted) begin
                    shift_reg <= {{(WIDTH-1){1'b0}}, bit_out};
                    fill      <= FILL_W'(1);
                end else begin
                    fill <= '0;
                end
            end else if (accepted) begin
                if (shift_full) begin
                    overrun <= 1'b1;
                end else begin
                    shift_reg <= {shift_reg[WIDTH-2:0], bit_out};
                    fill      <= fill + 1'b1;
                end
            end
        end
    end

endmodule
